// File: rtl/ibex_instr_mem_responder.sv
// Instruction-fetch responder: grants Ibex req/gnt fetches, reads a 1-cycle SRAM and
// returns in-order rvalid responses after a configurable number of extra pipeline stages.
module ibex_instr_mem_responder #(
    parameter int          NumReqs     = 2,
    parameter int          RespLatency = 0,
    parameter int          MemWords    = 1024,
    parameter logic [31:0] BaseAddr    = 32'h0000_0000
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        instr_req_i,
    output logic                        instr_gnt_o,
    input  logic [31:0]                 instr_addr_i,
    output logic                        instr_rvalid_o,
    output logic [31:0]                 instr_rdata_o,
    output logic                        instr_err_o,
    input  logic                        stall_i,
    output logic                        mem_en_o,
    output logic [$clog2(MemWords)-1:0] mem_addr_o,
    input  logic [31:0]                 mem_rdata_i,
    output logic                        busy_o
);

    localparam int          AddrW       = $clog2(MemWords);
    localparam int          CntW        = $clog2(NumReqs + 1);
    localparam logic [CntW-1:0] MaxCnt  = CntW'(NumReqs);
    localparam logic [32:0] WindowBytes = 33'(MemWords) << 2;

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     offset;
    logic            in_range;
    logic            s0_valid_q, s0_err_q;
    logic [31:0]     s0_rdata;
    logic            out_valid, out_err;
    logic [31:0]     out_rdata;

    // Offset is compared in 33 bits so a window ending at the top of the address space cannot overflow.
    assign offset   = instr_addr_i - BaseAddr;
    assign in_range = (instr_addr_i >= BaseAddr) && ({1'b0, offset} < WindowBytes)
                      && (offset[1:0] == 2'b00);

    assign instr_gnt_o = instr_req_i & ~stall_i & (cnt_q < MaxCnt);
    assign mem_en_o    = instr_gnt_o & in_range;
    assign mem_addr_o  = mem_en_o ? offset[AddrW+1:2] : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s0_valid_q <= 1'b0;
            s0_err_q   <= 1'b0;
        end else begin
            s0_valid_q <= instr_gnt_o;
            s0_err_q   <= instr_gnt_o & ~in_range;
        end
    end

    assign s0_rdata = s0_err_q ? 32'h0 : mem_rdata_i;

    generate
        if (RespLatency == 0) begin : g_direct
            assign out_valid = s0_valid_q;
            assign out_err   = s0_err_q;
            assign out_rdata = s0_rdata;
        end else begin : g_pipe
            logic        valid_q [RespLatency];
            logic        err_q   [RespLatency];
            logic [31:0] rdata_q [RespLatency];

            // No rvalid backpressure exists, so every stage shifts unconditionally.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    for (int i = 0; i < RespLatency; i++) begin
                        valid_q[i] <= 1'b0;
                        err_q[i]   <= 1'b0;
                        rdata_q[i] <= 32'h0;
                    end
                end else begin
                    valid_q[0] <= s0_valid_q;
                    err_q[0]   <= s0_err_q;
                    rdata_q[0] <= s0_rdata;
                    for (int i = 1; i < RespLatency; i++) begin
                        valid_q[i] <= valid_q[i-1];
                        err_q[i]   <= err_q[i-1];
                        rdata_q[i] <= rdata_q[i-1];
                    end
                end
            end

            assign out_valid = valid_q[RespLatency-1];
            assign out_err   = err_q[RespLatency-1];
            assign out_rdata = rdata_q[RespLatency-1];
        end
    endgenerate

    assign instr_rvalid_o = out_valid;
    assign instr_err_o    = out_valid & out_err;
    assign instr_rdata_o  = out_valid ? out_rdata : 32'h0;

    // A retiring response only frees its slot from the next cycle, since gnt uses cnt_q.
    always_comb begin
        cnt_d = cnt_q;
        case ({instr_gnt_o, out_valid})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy_o = (cnt_q != '0);

endmodule
